// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detection,
// mid-bit sampling, one-cycle rx_done / frame_err pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx_i,
    output logic [7:0] data_byte_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [13:0] LAST_CNT = 14'(CLKS_PER_BIT - 1);
    localparam logic [13:0] HALF_CNT = 14'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_n;
    logic        rx_meta, rx_s, rx_q;
    logic [13:0] baud_cnt, baud_cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift_reg, shift_reg_n;
    logic [7:0]  data_n;
    logic        done_n, ferr_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            rx_q          <= 1'b1;
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            data_byte_out <= '0;
            rx_done       <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            rx_meta       <= uart_rx_i;
            rx_s          <= rx_meta;
            rx_q          <= rx_s;
            state         <= state_n;
            baud_cnt      <= baud_cnt_n;
            bit_idx       <= bit_idx_n;
            shift_reg     <= shift_reg_n;
            data_byte_out <= data_n;
            rx_done       <= done_n;
            frame_err     <= ferr_n;
        end
    end

    always_comb begin
        state_n     = state;
        baud_cnt_n  = baud_cnt;
        bit_idx_n   = bit_idx;
        shift_reg_n = shift_reg;
        data_n      = data_byte_out;
        done_n      = 1'b0;
        ferr_n      = 1'b0;
        case (state)
            IDLE: begin
                // Only a genuine high-to-low transition starts a frame.
                if (rx_q && !rx_s) begin
                    state_n    = START;
                    baud_cnt_n = '0;
                end
            end
            START: begin
                if (baud_cnt == HALF_CNT) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = rx_s ? IDLE : DATA;
                end else begin
                    baud_cnt_n = baud_cnt + 14'd1;
                end
            end
            DATA: begin
                if (baud_cnt == LAST_CNT) begin
                    baud_cnt_n           = '0;
                    shift_reg_n[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 14'd1;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is seen.
                if (baud_cnt == LAST_CNT) begin
                    baud_cnt_n = '0;
                    state_n    = IDLE;
                    if (rx_s) begin
                        data_n = shift_reg;
                        done_n = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 14'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per bit period (100 MHz / 115200 baud); legal range 4..16383.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port uart_rx_i  input  1  serial line, asynchronous to clk; idle high.
REQ-005 SHALL have port data_byte_out  output  8  last correctly framed byte received; registered.
REQ-006 SHALL have port rx_done  output  1  one-cycle pulse; data_byte_out updated with a new byte this cycle.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-008 SHALL have port rx_busy  output  1  high in every state except IDLE.

Function
REQ-009 SHALL pass uart_rx_i through a 2-flop synchronizer; all logic below uses only the synchronized value (rx_s) and its one-cycle-delayed copy (rx_q).
REQ-010 SHALL use frame format: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), no parity.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, with a 14-bit baud counter and a 3-bit bit index.
REQ-012 IDLE: SHALL go to START and clear the baud counter on a falling edge (rx_q=1, rx_s=0); a line held low with no falling edge SHALL NOT start a frame.
REQ-013 START: SHALL count to (CLKS_PER_BIT-1)/2 (integer division) to reach mid start bit; if rx_s=0 there, go to DATA and clear counter and bit index; if rx_s=1, treat as a glitch and return to IDLE with no pulse.
REQ-014 DATA: SHALL sample rx_s when the counter reaches CLKS_PER_BIT-1, then clear the counter; sample i SHALL go to shift-register bit i; after bit index 7 is sampled, go to STOP.
REQ-015 STOP: SHALL sample rx_s after CLKS_PER_BIT-1 further counts (mid stop bit); if 1, load data_byte_out from the shift register and pulse rx_done; if 0, pulse frame_err and leave data_byte_out unchanged; go to IDLE in both cases.
REQ-016 rx_done and frame_err SHALL be high for exactly one clk cycle per frame, SHALL be registered, and SHALL never be high together.
REQ-017 Return to IDLE SHALL happen at mid stop bit, so a start bit immediately after the stop bit (back-to-back frames) is received.
REQ-018 data_byte_out SHALL hold its value until the next rx_done.
REQ-019 Latency: rx_done SHALL assert 2 (synchronizer) + 1 (edge detect) + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles after the first low uart_rx_i sample edge, within +/-1 cycle.
REQ-020 The baud counter SHALL never exceed CLKS_PER_BIT-1; no wrap-around is permitted within a bit.

Reset
REQ-021 When rst is asserted, the block SHALL immediately set FSM=IDLE, counters=0, shift register=0, data_byte_out=8'h00, rx_done=0, frame_err=0, rx_busy=0, and synchronizer flops=1.
REQ-022 Reset mid-frame SHALL abandon the frame with no pulse; after rst deasserts, the next falling edge SHALL be treated as a new start bit.

Verification (CLKS_PER_BIT=16)
REQ-023 Send 0xA5 with a correct frame -> exactly one rx_done pulse, data_byte_out=8'hA5, frame_err never high, rx_busy low after the pulse.
REQ-024 Send 0x00 then 0xFF back-to-back with zero idle bits -> two rx_done pulses about 160 cycles apart, data 8'h00 then 8'hFF.
REQ-025 Drive a 4-cycle low glitch on an idle line -> no rx_done, no frame_err, FSM back in IDLE within 12 cycles.
REQ-026 Send 0x3C with stop bit driven low -> one frame_err pulse, no rx_done, data_byte_out keeps its previous value; no new frame starts while the line stays low.
REQ-027 Assert rst during data bit 4 of 0x5A, release, then send 0x81 -> no pulse for the aborted frame, then rx_done with 8'h81.
REQ-028 Measure the cycle of the rx_done pulse for a single frame -> matches REQ-019: 2+1+7+144=154 cycles +/-1.
